peribus_controller: RTL and testbench
=====================================

// Module: peribus_controller
// PURPOSE
// Peripheral bus slave behind the memory unit's 0x300-0x3FF window (8-bit word offset).
// Decodes offset into a register file: ID, scratch, IRQ status/enable, down-timer, GPIO.
// Returns read data combinationally and aggregates peripheral interrupts onto one irq line.
// The memory unit gates irq with its own enable.
// PARAMETERS
// ID_VALUE     16'h5045  constant returned at offset 0x00
// GPIO_W       16        width of gpio_in/gpio_out (1..16)
// PORTS
// clk          in   1       clock; all state on rising edge
// reset_bar    in   1       reset, asynchronous, active-low
// addr         in   8       register word offset
// write_data   in   16      write payload
// write_enable in   1       write strobe, sampled at rising clk
// read_enable  in   1       read strobe (accepted; no read side effects in this block)
// read_data    out  16      combinational read of register at addr
// irq          out  1       |(irq_status & irq_enable), registered
// gpio_in      in   GPIO_W  asynchronous inputs
// gpio_out     out  GPIO_W  output register
// BEHAVIOUR
// Register map (offset, access, reset):
//  0x00 ID       RO  ID_VALUE
//  0x01 SCRATCH  RW  0
//  0x02 IRQ_STAT W1C 0   bit0 timer expiry, bit1 gpio_in rising edge, bit2 software irq
//  0x03 IRQ_EN   RW  0   bits[2:0] mask; bits[15:3] read 0
//  0x04 TMR_CTL  RW  0   bit0 run, bit1 auto-reload; other bits read 0
//  0x05 TMR_RLD  RW  0   reload value
//  0x06 TMR_CNT  RW  0   current count; write loads count directly
//  0x07 SWIRQ    WO      write with data[0]=1 sets IRQ_STAT[2]; reads 0
//  0x08 GPIO_OUT RW  0
//  0x09 GPIO_IN  RO      synchronized gpio_in, zero-extended
//  other offsets: read 16'h0000, writes ignored.
// - read_data: pure function of addr and current register state, no latency.
// - Writes commit on the rising clk edge where write_enable=1; one register per edge.
// - gpio_in: 2-flop synchronizer, then rising-edge detect vs previous synced value;
//   any bit rising sets IRQ_STAT[1] one edge later.
// - Timer: if run=1 and CNT!=0, CNT decrements by 1 per clk.
//   If run=1 and CNT==0: set IRQ_STAT[0]; then CNT<=RLD when auto-reload=1,
//   else run<=0 (CNT stays 0).
// - Write to TMR_CNT in the same cycle as a decrement: the write wins.
// - IRQ_STAT write-1-to-clear; a hardware set in the same cycle as a clear of the
//   same bit wins (bit reads 1).
// - irq: registered; asserts the clk after any masked status bit is 1.
// - Async reset clears every register, synchronizer, irq and gpio_out to 0,
//   including mid-count.
// STRUCTURE
// - Package peribus_pkg: localparam offsets (PB_ID..PB_GPIO_IN), IRQ bit indices,
//   typedef struct for TMR_CTL.
// - One sub-module, peribus_timer (run/reload/count/expire pulse); decode, IRQ and GPIO
//   stay in top.
// TESTING
// - Reset: read 0x00 ->16'h5045; 0x01,0x02,0x03,0x08 ->0; irq=0; gpio_out=0; 0x0A ->0.
// - Write 0x01=16'hBEEF, read ->BEEF; write 0x0A=1234, read 0x0A ->0000.
// - RLD=3, CNT=3, IRQ_EN=1, CTL=3 -> STAT[0]=1 after 4 clks, irq 1 clk later;
//   CNT reloads to 3; write 0x02=1 clears STAT[0]; irq drops next clk.
// - CTL=1 (one-shot), CNT=2 -> expires once; CTL reads 0; CNT holds 0.
// - gpio_in bit0 0->1 with IRQ_EN=2 -> STAT[1]=1 within 3 clks, irq=1;
//   W1C clear same cycle as new edge -> bit stays 1.
// - SWIRQ write 1, IRQ_EN=0 -> STAT[2]=1, irq=0; assert reset_bar low mid-timer ->
//   all regs 0 immediately.

Source files
------------

// File: rtl/peribus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : peribus_pkg
// Purpose  : Register offsets, IRQ bit indices and timer control layout
// Revision : 1.0 - initial release
// ============================================================================
package peribus_pkg;

   localparam logic [7:0] PB_ID       = 8'h00;
   localparam logic [7:0] PB_SCRATCH  = 8'h01;
   localparam logic [7:0] PB_IRQ_STAT = 8'h02;
   localparam logic [7:0] PB_IRQ_EN   = 8'h03;
   localparam logic [7:0] PB_TMR_CTL  = 8'h04;
   localparam logic [7:0] PB_TMR_RLD  = 8'h05;
   localparam logic [7:0] PB_TMR_CNT  = 8'h06;
   localparam logic [7:0] PB_SWIRQ    = 8'h07;
   localparam logic [7:0] PB_GPIO_OUT = 8'h08;
   localparam logic [7:0] PB_GPIO_IN  = 8'h09;

   localparam int IRQ_TMR  = 0;
   localparam int IRQ_GPIO = 1;
   localparam int IRQ_SW   = 2;
   localparam int IRQ_N    = 3;

   typedef struct packed {
      logic auto_reload;
      logic run;
   } tmr_ctl_t;

endpackage
`default_nettype wire

// File: rtl/peribus_timer.sv
`default_nettype none
// ============================================================================
// Module   : peribus_timer
// Purpose  : Down-counter with run/auto-reload control and expiry pulse
// Revision : 1.0 - initial release
// ============================================================================
module peribus_timer
   import peribus_pkg::*;
(
   input  logic        clk,
   input  logic        reset_bar,
   input  logic        ctl_we,
   input  logic        rld_we,
   input  logic        cnt_we,
   input  logic [15:0] wdata,
   output tmr_ctl_t    ctl,
   output logic [15:0] rld,
   output logic [15:0] cnt,
   output logic        expire
);

   tmr_ctl_t    r_ctl;
   logic [15:0] r_rld;
   logic [15:0] r_cnt;
   logic        w_expire;

   assign w_expire = r_ctl.run && (r_cnt == 16'h0000);

   always_ff @(posedge clk or negedge reset_bar) begin
      if (!reset_bar) begin
         r_ctl <= '0;
         r_rld <= '0;
         r_cnt <= '0;
      end else begin
         if (rld_we)
            r_rld <= wdata;

         if (ctl_we)
            r_ctl <= tmr_ctl_t'(wdata[1:0]);
         else if (w_expire && !r_ctl.auto_reload)
            r_ctl.run <= 1'b0;

         // A bus write to the count overrides the decrement/reload path.
         if (cnt_we)
            r_cnt <= wdata;
         else if (r_ctl.run) begin
            if (r_cnt != 16'h0000)
               r_cnt <= r_cnt - 16'h0001;
            else if (r_ctl.auto_reload)
               r_cnt <= r_rld;
         end
      end
   end

   assign ctl    = r_ctl;
   assign rld    = r_rld;
   assign cnt    = r_cnt;
   assign expire = w_expire;

endmodule
`default_nettype wire

// File: rtl/peribus_controller.sv
`default_nettype none
// ============================================================================
// Module   : peribus_controller
// Purpose  : Peripheral register slave: ID, scratch, IRQ, timer and GPIO
// Revision : 1.0 - initial release
// ============================================================================
module peribus_controller
   import peribus_pkg::*;
#(
   parameter logic [15:0] ID_VALUE = 16'h5045,
   parameter int          GPIO_W   = 16
) (
   input  logic              clk,
   input  logic              reset_bar,
   input  logic [7:0]        addr,
   input  logic [15:0]       write_data,
   input  logic              write_enable,
   input  logic              read_enable,
   output logic [15:0]       read_data,
   output logic              irq,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out
);

   logic [15:0]       r_scratch;
   logic [IRQ_N-1:0]  r_irq_stat;
   logic [IRQ_N-1:0]  r_irq_en;
   logic [GPIO_W-1:0] r_gpio_out;
   logic [GPIO_W-1:0] r_sync1;
   logic [GPIO_W-1:0] r_sync2;
   logic [GPIO_W-1:0] r_sync_prev;
   logic              r_irq;

   tmr_ctl_t          w_tmr_ctl;
   logic [15:0]       w_tmr_rld;
   logic [15:0]       w_tmr_cnt;
   logic              w_tmr_expire;
   logic [IRQ_N-1:0]  w_stat_set;
   logic [IRQ_N-1:0]  w_stat_clr;
   logic [15:0]       w_gpio_in_ext;
   logic [15:0]       w_gpio_out_ext;
   logic              w_unused_read_enable;

   // This block has no read side effects, so the strobe is intentionally unused.
   assign w_unused_read_enable = read_enable;

   peribus_timer u_timer (
      .clk       (clk),
      .reset_bar (reset_bar),
      .ctl_we    (write_enable && (addr == PB_TMR_CTL)),
      .rld_we    (write_enable && (addr == PB_TMR_RLD)),
      .cnt_we    (write_enable && (addr == PB_TMR_CNT)),
      .wdata     (write_data),
      .ctl       (w_tmr_ctl),
      .rld       (w_tmr_rld),
      .cnt       (w_tmr_cnt),
      .expire    (w_tmr_expire)
   );

   always_comb begin
      w_stat_set           = '0;
      w_stat_set[IRQ_TMR]  = w_tmr_expire;
      w_stat_set[IRQ_GPIO] = |(r_sync2 & ~r_sync_prev);
      w_stat_set[IRQ_SW]   = write_enable && (addr == PB_SWIRQ) && write_data[0];
      w_stat_clr           = '0;
      if (write_enable && (addr == PB_IRQ_STAT))
         w_stat_clr = write_data[IRQ_N-1:0];
   end

   always_ff @(posedge clk or negedge reset_bar) begin
      if (!reset_bar) begin
         r_scratch   <= '0;
         r_irq_stat  <= '0;
         r_irq_en    <= '0;
         r_gpio_out  <= '0;
         r_sync1     <= '0;
         r_sync2     <= '0;
         r_sync_prev <= '0;
         r_irq       <= 1'b0;
      end else begin
         r_sync1     <= gpio_in;
         r_sync2     <= r_sync1;
         r_sync_prev <= r_sync2;
         // Set is ORed after the clear so a concurrent hardware event is never lost.
         r_irq_stat  <= (r_irq_stat & ~w_stat_clr) | w_stat_set;
         r_irq       <= |(r_irq_stat & r_irq_en);
         if (write_enable) begin
            case (addr)
               PB_SCRATCH:  r_scratch  <= write_data;
               PB_IRQ_EN:   r_irq_en   <= write_data[IRQ_N-1:0];
               PB_GPIO_OUT: r_gpio_out <= write_data[GPIO_W-1:0];
               default:     ;
            endcase
         end
      end
   end

   always_comb begin
      w_gpio_in_ext                 = '0;
      w_gpio_in_ext[GPIO_W-1:0]     = r_sync2;
      w_gpio_out_ext                = '0;
      w_gpio_out_ext[GPIO_W-1:0]    = r_gpio_out;
   end

   always_comb begin
      read_data = 16'h0000;
      case (addr)
         PB_ID:       read_data = ID_VALUE;
         PB_SCRATCH:  read_data = r_scratch;
         PB_IRQ_STAT: read_data = {13'h0000, r_irq_stat};
         PB_IRQ_EN:   read_data = {13'h0000, r_irq_en};
         PB_TMR_CTL:  read_data = {14'h0000, w_tmr_ctl};
         PB_TMR_RLD:  read_data = w_tmr_rld;
         PB_TMR_CNT:  read_data = w_tmr_cnt;
         PB_GPIO_OUT: read_data = w_gpio_out_ext;
         PB_GPIO_IN:  read_data = w_gpio_in_ext;
         default:     read_data = 16'h0000;
      endcase
   end

   assign irq      = r_irq;
   assign gpio_out = r_gpio_out;

endmodule
`default_nettype wire

// File: tb/tb_peribus_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_peribus_controller
// Purpose  : Directed self-checking bench for peribus_controller
// Revision : 1.0 - initial release
// ============================================================================
module tb_peribus_controller;

   logic        clk = 1'b0;
   logic        reset_bar;
   logic [7:0]  addr;
   logic [15:0] write_data;
   logic        write_enable;
   logic        read_enable;
   logic [15:0] read_data;
   logic        irq;
   logic [15:0] gpio_in;
   logic [15:0] gpio_out;

   int n_checks = 0;
   int n_errors = 0;

   peribus_controller #(.ID_VALUE(16'h5045), .GPIO_W(16)) dut (
      .clk          (clk),
      .reset_bar    (reset_bar),
      .addr         (addr),
      .write_data   (write_data),
      .write_enable (write_enable),
      .read_enable  (read_enable),
      .read_data    (read_data),
      .irq          (irq),
      .gpio_in      (gpio_in),
      .gpio_out     (gpio_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] d);
      @(negedge clk);
      addr         = a;
      write_data   = d;
      write_enable = 1'b1;
      @(posedge clk);
      #1;
      write_enable = 1'b0;
   endtask

   task automatic chk_rd(input string tag, input logic [7:0] a, input logic [15:0] exp);
      addr        = a;
      read_enable = 1'b1;
      #1;
      check(tag, read_data, exp);
      read_enable = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset_bar    = 1'b0;
      addr         = 8'h00;
      write_data   = 16'h0000;
      write_enable = 1'b0;
      read_enable  = 1'b0;
      gpio_in      = 16'h0000;
      #22;
      check("rst_irq", {15'h0, irq}, 16'h0000);
      check("rst_gpio_out", gpio_out, 16'h0000);
      @(negedge clk);
      reset_bar = 1'b1;
      tick(1);

      chk_rd("rst_id", 8'h00, 16'h5045);
      chk_rd("rst_scratch", 8'h01, 16'h0000);
      chk_rd("rst_stat", 8'h02, 16'h0000);
      chk_rd("rst_en", 8'h03, 16'h0000);
      chk_rd("rst_gpio_out_reg", 8'h08, 16'h0000);
      chk_rd("rst_unmapped", 8'h0A, 16'h0000);

      wr(8'h01, 16'hBEEF);
      chk_rd("scratch", 8'h01, 16'hBEEF);
      wr(8'h0A, 16'h1234);
      chk_rd("unmapped_wr", 8'h0A, 16'h0000);
      wr(8'h08, 16'hA5C3);
      chk_rd("gpio_out_reg", 8'h08, 16'hA5C3);
      check("gpio_out_port", gpio_out, 16'hA5C3);
      wr(8'h03, 16'hFFF8);
      chk_rd("en_upper_ro", 8'h03, 16'h0000);
      wr(8'h04, 16'hFFFC);
      chk_rd("ctl_upper_ro", 8'h04, 16'h0000);

      // Auto-reload timer: expiry four edges after run is set.
      wr(8'h05, 16'd3);
      wr(8'h06, 16'd3);
      wr(8'h03, 16'h0001);
      wr(8'h04, 16'h0003);
      chk_rd("tmr_cnt_start", 8'h06, 16'd3);
      tick(3);
      chk_rd("tmr_cnt_zero", 8'h06, 16'd0);
      chk_rd("tmr_stat_pre", 8'h02, 16'h0000);
      tick(1);
      chk_rd("tmr_stat_set", 8'h02, 16'h0001);
      chk_rd("tmr_reload", 8'h06, 16'd3);
      check("tmr_irq_lag", {15'h0, irq}, 16'h0000);
      tick(1);
      check("tmr_irq", {15'h0, irq}, 16'h0001);
      wr(8'h02, 16'h0001);
      chk_rd("tmr_w1c", 8'h02, 16'h0000);
      check("tmr_irq_hold", {15'h0, irq}, 16'h0001);
      wr(8'h04, 16'h0000);
      check("tmr_irq_drop", {15'h0, irq}, 16'h0000);
      chk_rd("tmr_stopped", 8'h04, 16'h0000);

      // One-shot timer.
      wr(8'h06, 16'd2);
      wr(8'h04, 16'h0001);
      tick(3);
      chk_rd("os_stat", 8'h02, 16'h0001);
      chk_rd("os_ctl", 8'h04, 16'h0000);
      chk_rd("os_cnt", 8'h06, 16'd0);
      tick(2);
      chk_rd("os_cnt_hold", 8'h06, 16'd0);
      wr(8'h02, 16'h0001);
      chk_rd("os_clr", 8'h02, 16'h0000);

      // GPIO rising edge interrupt.
      wr(8'h03, 16'h0002);
      gpio_in = 16'h0001;
      tick(3);
      chk_rd("gpio_stat", 8'h02, 16'h0002);
      chk_rd("gpio_in_reg", 8'h09, 16'h0001);
      tick(1);
      check("gpio_irq", {15'h0, irq}, 16'h0001);
      gpio_in = 16'h0000;
      tick(4);
      gpio_in = 16'h0001;
      tick(2);
      wr(8'h02, 16'h0002);
      chk_rd("gpio_set_wins", 8'h02, 16'h0002);
      wr(8'h02, 16'h0002);
      chk_rd("gpio_clr", 8'h02, 16'h0000);

      // Software interrupt with mask off.
      wr(8'h03, 16'h0000);
      wr(8'h07, 16'h0001);
      chk_rd("swirq_stat", 8'h02, 16'h0004);
      chk_rd("swirq_rd0", 8'h07, 16'h0000);
      tick(2);
      check("swirq_masked", {15'h0, irq}, 16'h0000);

      // Asynchronous reset in the middle of a count.
      wr(8'h05, 16'd100);
      wr(8'h06, 16'd50);
      wr(8'h04, 16'h0003);
      tick(5);
      chk_rd("pre_rst_cnt", 8'h06, 16'd45);
      #2;
      reset_bar = 1'b0;
      #1;
      chk_rd("arst_cnt", 8'h06, 16'h0000);
      chk_rd("arst_ctl", 8'h04, 16'h0000);
      chk_rd("arst_rld", 8'h05, 16'h0000);
      chk_rd("arst_scratch", 8'h01, 16'h0000);
      chk_rd("arst_stat", 8'h02, 16'h0000);
      chk_rd("arst_gpio_in", 8'h09, 16'h0000);
      check("arst_gpio_out", gpio_out, 16'h0000);
      check("arst_irq", {15'h0, irq}, 16'h0000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
